// File: rtl/regfile_wb_arb_if.sv
// Writeback arbiter bus: ALU result port, LSU result handshake, LSU issue
// tracking, pending scoreboard and the registered register-file write port.
interface regfile_wb_arb_if;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_stall;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        lsu_issue_en;
   logic [4:0]  lsu_issue_rd;
   logic [31:0] pending;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   modport master (
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
             lsu_issue_en, lsu_issue_rd,
      input  alu_stall, lsu_ready, pending, wb_en, wb_rd, wb_data
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
             lsu_issue_en, lsu_issue_rd,
      output alu_stall, lsu_ready, pending, wb_en, wb_rd, wb_data
   );
endinterface

// File: rtl/regfile_wb_arb.sv
// Register-file writeback arbiter. Single-cycle ALU results have priority;
// LSU results queue in a 2-entry FIFO and are written back when the ALU is
// idle, or forcibly after the ALU has won four times in a row while the FIFO
// held data. A pending scoreboard tracks registers awaiting an LSU writeback.
module regfile_wb_arb (
   input logic               clk,
   input logic               rst,
   regfile_wb_arb_if.slave   bus
);

   logic [4:0]  r_fifo_rd   [0:1];
   logic [31:0] r_fifo_data [0:1];
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [1:0]  r_count;
   logic [2:0]  r_starve;
   logic [31:0] r_pending;
   logic        r_wb_en;
   logic        r_wb_lsu;
   logic [4:0]  r_wb_rd;
   logic [31:0] r_wb_data;

   logic        w_alu_stall;
   logic        w_lsu_ready;
   logic        w_push;
   logic        w_alu_win;
   logic        w_fifo_win;
   logic        w_win_valid;
   logic [4:0]  w_win_rd;
   logic [31:0] w_win_data;
   logic [2:0]  w_starve_nxt;
   logic [31:0] w_set_mask;
   logic [31:0] w_clr_mask;
   logic [31:0] w_pending_nxt;

   // Arbitration, handshake, starvation and scoreboard next-state decode.
   always_comb begin
      w_alu_stall = (r_count != 2'd0) && (r_starve == 3'd4);
      w_lsu_ready = (r_count < 2'd2);
      w_push      = bus.lsu_valid && w_lsu_ready;
      w_alu_win   = bus.alu_valid && !w_alu_stall;
      w_fifo_win  = !w_alu_win && (r_count != 2'd0);
      w_win_valid = w_alu_win || w_fifo_win;
      if (w_alu_win) begin
         w_win_rd   = bus.alu_rd;
         w_win_data = bus.alu_data;
      end else begin
         w_win_rd   = r_fifo_rd[r_rd_ptr];
         w_win_data = r_fifo_data[r_rd_ptr];
      end
      // Starvation only accumulates while an LSU result is actually waiting.
      if (w_alu_win && (r_count != 2'd0)) begin
         w_starve_nxt = (r_starve == 3'd4) ? 3'd4 : (r_starve + 3'd1);
      end else begin
         w_starve_nxt = 3'd0;
      end
      if (bus.lsu_issue_en) begin
         w_set_mask = 32'd1 << bus.lsu_issue_rd;
      end else begin
         w_set_mask = 32'd0;
      end
      // Clear one edge after an LSU-sourced write is visible on the wb port.
      if (r_wb_en && r_wb_lsu) begin
         w_clr_mask = 32'd1 << r_wb_rd;
      end else begin
         w_clr_mask = 32'd0;
      end
      // Set is applied after clear so it wins; x0 is never pending.
      w_pending_nxt = ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'd1;
   end

   // LSU result FIFO storage and pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fifo_rd[0]   <= 5'd0;
         r_fifo_rd[1]   <= 5'd0;
         r_fifo_data[0] <= 32'd0;
         r_fifo_data[1] <= 32'd0;
         r_wr_ptr       <= 1'b0;
         r_rd_ptr       <= 1'b0;
         r_count        <= 2'd0;
      end else begin
         if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= bus.lsu_rd;
            r_fifo_data[r_wr_ptr] <= bus.lsu_data;
            r_wr_ptr              <= ~r_wr_ptr;
         end
         if (w_fifo_win) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         if (w_push && !w_fifo_win) begin
            r_count <= r_count + 2'd1;
         end else if (!w_push && w_fifo_win) begin
            r_count <= r_count - 2'd1;
         end
      end
   end

   // Starvation counter and pending scoreboard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starve  <= 3'd0;
         r_pending <= 32'd0;
      end else begin
         r_starve  <= w_starve_nxt;
         r_pending <= w_pending_nxt;
      end
   end

   // Registered writeback port; rd/data hold when nothing is written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_en   <= 1'b0;
         r_wb_lsu  <= 1'b0;
         r_wb_rd   <= 5'd0;
         r_wb_data <= 32'd0;
      end else begin
         r_wb_en  <= w_win_valid && (w_win_rd != 5'd0);
         r_wb_lsu <= w_fifo_win;
         if (w_win_valid && (w_win_rd != 5'd0)) begin
            r_wb_rd   <= w_win_rd;
            r_wb_data <= w_win_data;
         end
      end
   end

   assign bus.alu_stall = w_alu_stall;
   assign bus.lsu_ready = w_lsu_ready;
   assign bus.pending   = r_pending;
   assign bus.wb_en     = r_wb_en;
   assign bus.wb_rd     = r_wb_rd;
   assign bus.wb_data   = r_wb_data;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Bench for regfile_wb_arb: directed stimulus, a queue-based reference model
// checked every cycle, and literal expectations for each scenario.
module tb_regfile_wb_arb;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   regfile_wb_arb_if bus ();

   regfile_wb_arb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model state
   ent_t        mq[$];
   int          m_starve   = 0;
   logic [31:0] m_pending  = 32'd0;
   logic        m_wb_en    = 1'b0;
   logic        m_wb_lsu   = 1'b0;
   logic [4:0]  m_wb_rd    = 5'd0;
   logic [31:0] m_wb_data  = 32'd0;
   int          m_n;
   bit          m_stall, m_ready, m_alu_w, m_fifo_w, m_win;
   ent_t        m_ent;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue semantics straight from the arbitration rules.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_starve  = 0;
         m_pending = 32'd0;
         m_wb_en   = 1'b0;
         m_wb_lsu  = 1'b0;
         m_wb_rd   = 5'd0;
         m_wb_data = 32'd0;
      end else begin
         m_n      = mq.size();
         m_stall  = (m_n > 0) && (m_starve == 4);
         m_ready  = (m_n < 2);
         m_alu_w  = bus.alu_valid && !m_stall;
         m_fifo_w = !m_alu_w && (m_n > 0);
         m_win    = m_alu_w || m_fifo_w;
         if (m_wb_en && m_wb_lsu) m_pending[m_wb_rd] = 1'b0;
         if (bus.lsu_issue_en && bus.lsu_issue_rd != 5'd0) m_pending[bus.lsu_issue_rd] = 1'b1;
         if (m_alu_w) begin
            m_ent.rd   = bus.alu_rd;
            m_ent.data = bus.alu_data;
         end else if (m_fifo_w) begin
            m_ent = mq.pop_front();
         end
         m_wb_lsu = m_fifo_w;
         if (m_win && m_ent.rd != 5'd0) begin
            m_wb_en   = 1'b1;
            m_wb_rd   = m_ent.rd;
            m_wb_data = m_ent.data;
         end else begin
            m_wb_en = 1'b0;
         end
         if (m_alu_w && m_n > 0) m_starve = (m_starve >= 4) ? 4 : m_starve + 1;
         else m_starve = 0;
         if (bus.lsu_valid && m_ready) mq.push_back({bus.lsu_rd, bus.lsu_data});
      end
   end

   // Compare every output against the model on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("wb_en",     {31'd0, bus.wb_en},     {31'd0, m_wb_en});
         chk("wb_rd",     {27'd0, bus.wb_rd},     {27'd0, m_wb_rd});
         chk("wb_data",   bus.wb_data,            m_wb_data);
         chk("pending",   bus.pending,            m_pending);
         chk("lsu_ready", {31'd0, bus.lsu_ready}, {31'd0, mq.size() < 2});
         chk("alu_stall", {31'd0, bus.alu_stall}, {31'd0, (mq.size() > 0) && (m_starve == 4)});
      end
   end

   // Apply one cycle of inputs; returns 1 time unit after the consuming edge.
   task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic ie, input logic [4:0] ird);
      bus.alu_valid    = av;
      bus.alu_rd       = ard;
      bus.alu_data     = ad;
      bus.lsu_valid    = lv;
      bus.lsu_rd       = lrd;
      bus.lsu_data     = ld;
      bus.lsu_issue_en = ie;
      bus.lsu_issue_rd = ird;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
   endtask

   initial begin
      bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
      bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = 32'd0;
      bus.lsu_issue_en = 1'b0; bus.lsu_issue_rd = 5'd0;
      #1;
      chk("rst_wb_en",     {31'd0, bus.wb_en},     32'd0);
      chk("rst_wb_rd",     {27'd0, bus.wb_rd},     32'd0);
      chk("rst_wb_data",   bus.wb_data,            32'd0);
      chk("rst_pending",   bus.pending,            32'd0);
      chk("rst_lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
      chk("rst_alu_stall", {31'd0, bus.alu_stall}, 32'd0);
      #11 rst = 1'b0;
      @(posedge clk); #1;

      // ALU only
      drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      chk("alu_wb_en",   {31'd0, bus.wb_en}, 32'd1);
      chk("alu_wb_rd",   {27'd0, bus.wb_rd}, 32'd5);
      chk("alu_wb_data", bus.wb_data,        32'hDEAD_BEEF);
      idle();
      chk("hold_wb_en",   {31'd0, bus.wb_en}, 32'd0);
      chk("hold_wb_rd",   {27'd0, bus.wb_rd}, 32'd5);
      chk("hold_wb_data", bus.wb_data,        32'hDEAD_BEEF);

      // Contention: ALU rd3 and LSU rd7 together
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      chk("issue_pend7", bus.pending, 32'h0000_0080);
      drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h11, 1'b0, 5'd0);
      chk("cont_alu_rd", {27'd0, bus.wb_rd}, 32'd3);
      idle();
      chk("cont_lsu_en",   {31'd0, bus.wb_en}, 32'd1);
      chk("cont_lsu_rd",   {27'd0, bus.wb_rd}, 32'd7);
      chk("cont_lsu_data", bus.wb_data,        32'h11);
      chk("cont_pend_hold", bus.pending,       32'h0000_0080);
      idle();
      chk("cont_pend_clr", bus.pending, 32'd0);

      // FIFO full with ALU busy; third LSU result is held
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd8, 32'h80, 1'b0, 5'd0);
      drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd9, 32'h90, 1'b0, 5'd0);
      chk("full_ready", {31'd0, bus.lsu_ready}, 32'd0);
      drive(1'b1, 5'd4, 32'h4, 1'b1, 5'd10, 32'hA0, 1'b0, 5'd0);
      chk("full_ready2", {31'd0, bus.lsu_ready}, 32'd0);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA0, 1'b0, 5'd0);
      chk("pop1_rd",    {27'd0, bus.wb_rd},     32'd8);
      chk("pop1_ready", {31'd0, bus.lsu_ready}, 32'd1);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA0, 1'b0, 5'd0);
      chk("pop2_rd", {27'd0, bus.wb_rd}, 32'd9);
      idle();
      chk("pop3_rd",   {27'd0, bus.wb_rd}, 32'd10);
      chk("pop3_data", bus.wb_data,        32'hA0);
      idle();

      // Starvation: one queued LSU entry vs continuous ALU traffic
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hB0, 1'b0, 5'd0);
      for (int i = 0; i < 4; i++) begin
         chk("starve_pre", {31'd0, bus.alu_stall}, 32'd0);
         drive(1'b1, 5'd12, 32'hC0 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
         chk("starve_alu_rd", {27'd0, bus.wb_rd}, 32'd12);
      end
      chk("starve_stall", {31'd0, bus.alu_stall}, 32'd1);
      drive(1'b1, 5'd12, 32'hC4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      chk("starve_lsu_rd",   {27'd0, bus.wb_rd},     32'd11);
      chk("starve_lsu_data", bus.wb_data,            32'hB0);
      chk("starve_release",  {31'd0, bus.alu_stall}, 32'd0);
      drive(1'b1, 5'd12, 32'hC4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      chk("starve_alu_back", bus.wb_data, 32'hC4);
      idle();

      // rd = 0 handling
      drive(1'b1, 5'd0, 32'h5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      chk("rd0_alu_en", {31'd0, bus.wb_en}, 32'd0);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h6, 1'b1, 5'd0);
      chk("rd0_pending", bus.pending, 32'd0);
      idle();
      chk("rd0_lsu_en", {31'd0, bus.wb_en}, 32'd0);
      idle();

      // Reset mid-queue
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd13, 32'hD0, 1'b1, 5'd13);
      drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd14, 32'hE0, 1'b0, 5'd0);
      chk("mq_full",   {31'd0, bus.lsu_ready}, 32'd0);
      chk("mq_pend13", bus.pending,            32'h0000_2000);
      bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_wb_en",   {31'd0, bus.wb_en},     32'd0);
      chk("arst_ready",   {31'd0, bus.lsu_ready}, 32'd1);
      chk("arst_pending", bus.pending,            32'd0);
      #2 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idle();
         chk("arst_no_wb", {31'd0, bus.wb_en}, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset; all state SHALL clear immediately on rst=1, independent of clk.
REQ-002 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- alu_valid  in  1  single-cycle ALU result present.
- alu_rd  in  5  ALU destination index.
- alu_data  in  32  ALU result.
- alu_stall  out  1  ALU result not taken this cycle; upstream holds it.
- lsu_valid  in  1  load/long-latency result offered.
- lsu_ready  out  1  FIFO can accept an LSU result.
- lsu_rd  in  5  LSU destination index.
- lsu_data  in  32  LSU result.
- lsu_issue_en  in  1  LSU op issued; mark rd pending.
- lsu_issue_rd  in  5  issued LSU destination.
- pending  out  32  bit i=1: register i awaits an LSU writeback.
- wb_en  out  1  register-file write enable (registered).
- wb_rd  out  5  register-file write index (registered).
- wb_data  out  32  register-file write data (registered).

Function
REQ-003 LSU results SHALL enter a 2-entry FIFO; the handshake completes when lsu_valid=1 and lsu_ready=1 on a rising edge.
REQ-004 lsu_ready SHALL equal (count<2) and SHALL depend only on registered state; a same-cycle pop SHALL NOT raise it.
REQ-005 Each cycle the arbiter SHALL pick one winner:
- ALU if alu_valid=1 and alu_stall=0;
- otherwise the FIFO head if count>0;
- otherwise none.
REQ-006 The winner SHALL appear on wb_en/wb_rd/wb_data at the next rising edge (latency 1); with no winner, wb_en SHALL be 0 and wb_rd/wb_data SHALL hold their previous values.
REQ-007 A winner with rd=0 SHALL be consumed (ALU accepted, or FIFO popped) with wb_en=0 on the following cycle.
REQ-008 A starvation counter starve_cnt (3 bits) SHALL:
- increment when count>0 and the ALU wins;
- reset to 0 when the FIFO wins or count=0;
- saturate at 4.
REQ-009 alu_stall SHALL equal (count>0 && starve_cnt==4) combinationally; while it is 1 the FIFO head SHALL win regardless of alu_valid.
REQ-010 FIFO push and pop in the same cycle SHALL leave count unchanged and preserve order; a pop from count=1 with a simultaneous push SHALL make the pushed entry the head.
REQ-011 pending[lsu_issue_rd] SHALL be set at the edge where lsu_issue_en=1, except index 0.
REQ-012 pending[wb_rd] SHALL clear at the edge following the cycle a FIFO entry is written back (wb_en=1 from LSU source).
REQ-013 If a set and a clear target the same bit in one edge, set SHALL win; pending[0] SHALL always read 0.
REQ-014 ALU writebacks SHALL NOT modify pending.

Reset
REQ-015 On rst=1 the block SHALL force:
- wb_en=0, wb_rd=0, wb_data=0;
- FIFO count=0 and pointers=0;
- starve_cnt=0;
- pending=0;
- hence lsu_ready=1 and alu_stall=0.
REQ-016 Reset asserted mid-operation SHALL discard queued FIFO entries without writing them back.

Verification
REQ-017 Bench SHALL cover:
- ALU only: alu_valid=1, rd=5, data=0xDEAD_BEEF -> next cycle wb_en=1, wb_rd=5, wb_data=0xDEADBEEF.
- Contention: alu_valid=1 (rd=3) and lsu push (rd=7, 0x11) in the same cycle -> ALU writes first; LSU rd=7 writes the next idle cycle; pending[7] clears one edge later.
- FIFO full: two LSU pushes with ALU busy -> lsu_ready=0; a third lsu_valid is held, not lost, and is accepted after the first pop.
- Starvation: FIFO count=1 with alu_valid held high -> ALU wins 4 cycles, then alu_stall=1 for one cycle and the LSU entry writes back; alu_stall returns to 0.
- rd=0: ALU rd=0 data=0x5 -> wb_en stays 0; lsu_issue_rd=0 -> pending stays 0.
- Reset mid-queue: count=2, rst pulsed asynchronously -> wb_en=0, lsu_ready=1, pending=0 immediately, and no queued entry is ever written back.
